// File: rtl/ul4_acc_seq_if.sv
// ----------------------------------------------------------------------------
// ul4_acc_seq_if
// Bundles the operand-beat handshake, the ul4 drive/return lines and the
// result handshake of ul4_acc_seq.
//   slave  : seen by ul4_acc_seq (accepts beats, drives ul4, offers result)
//   master : seen by the beat source / result sink / external ul4
// Optional macro UL4_ACC_FLAGS_EN adds res_zero and res_par.
// ----------------------------------------------------------------------------
interface ul4_acc_seq_if #(
    parameter int W  = 4,
    parameter int CW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic          in_first;
    logic          in_last;
    logic [W-1:0]  in_B;
    logic [1:0]    in_S;
    logic [W-1:0]  ul_A;
    logic [W-1:0]  ul_B;
    logic [1:0]    ul_S;
    logic [W-1:0]  ul_Out;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_data;
    logic [CW-1:0] res_count;
`ifdef UL4_ACC_FLAGS_EN
    logic          res_zero;
    logic          res_par;

    modport slave (
        input  in_valid, in_first, in_last, in_B, in_S, ul_Out, res_ready,
        output in_ready, ul_A, ul_B, ul_S, res_valid, res_data, res_count,
               res_zero, res_par
    );
    modport master (
        output in_valid, in_first, in_last, in_B, in_S, ul_Out, res_ready,
        input  in_ready, ul_A, ul_B, ul_S, res_valid, res_data, res_count,
               res_zero, res_par
    );
`else
    modport slave (
        input  in_valid, in_first, in_last, in_B, in_S, ul_Out, res_ready,
        output in_ready, ul_A, ul_B, ul_S, res_valid, res_data, res_count
    );
    modport master (
        output in_valid, in_first, in_last, in_B, in_S, ul_Out, res_ready,
        input  in_ready, ul_A, ul_B, ul_S, res_valid, res_data, res_count
    );
`endif
endinterface

// File: rtl/ul4_acc_seq.sv
// ----------------------------------------------------------------------------
// ul4_acc_seq
// Operand sequencer and accumulator around an external combinational ul4.
// A sequence starts with a load beat (acc <= operand), each further beat runs
// one ul4 operation (acc <= ul4(acc, B, S)), and the final value is offered on
// the result handshake together with the saturating operation count.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      ul4_acc_seq_if.slave: in_* beat handshake, ul_A/ul_B/ul_S to ul4,
//            ul_Out from ul4, res_* result handshake
// Optional macro UL4_ACC_FLAGS_EN: adds registered res_zero (acc==0) and
// res_par (^acc).
// ----------------------------------------------------------------------------
module ul4_acc_seq #(
    parameter int W  = 4,
    parameter int CW = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    ul4_acc_seq_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EXEC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_b;
    logic [1:0]    r_s;
    logic [CW-1:0] r_cnt;
    logic          r_last_pend;

    logic          w_ready;
    logic          w_res_valid;
    logic          w_load_first;
    logic          w_load_op;
    logic          w_exec;
    logic          w_acc_en;
    logic [W-1:0]  w_acc_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ready      = 1'b0;
        w_res_valid  = 1'b0;
        w_load_first = 1'b0;
        w_load_op    = 1'b0;
        w_exec       = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                // Any beat in IDLE starts a sequence, whatever in_first says.
                if (bus.in_valid) begin
                    w_load_first = 1'b1;
                    w_state_nxt  = bus.in_last ? DONE : WAIT;
                end
            end
            WAIT: begin
                w_ready = 1'b1;
                if (bus.in_valid) begin
                    if (bus.in_first) begin
                        w_load_first = 1'b1;
                        w_state_nxt  = bus.in_last ? DONE : WAIT;
                    end else begin
                        w_load_op   = 1'b1;
                        w_state_nxt = EXEC;
                    end
                end
            end
            EXEC: begin
                w_exec      = 1'b1;
                w_state_nxt = r_last_pend ? DONE : WAIT;
            end
            DONE: begin
                w_res_valid = 1'b1;
                if (bus.res_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Accumulator source: operand on a load beat, ul4 result during EXEC.
    assign w_acc_en = w_load_first | w_exec;
    assign w_acc_d  = w_load_first ? bus.in_B : bus.ul_Out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc       <= '0;
            r_b         <= '0;
            r_s         <= '0;
            r_cnt       <= '0;
            r_last_pend <= 1'b0;
        end else begin
            if (w_acc_en) r_acc <= w_acc_d;
            if (w_load_first) r_cnt <= '0;
            else if (w_exec && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            if (w_load_op) begin
                r_b         <= bus.in_B;
                r_s         <= bus.in_S;
                r_last_pend <= bus.in_last;
            end
        end
    end

`ifdef UL4_ACC_FLAGS_EN
    logic r_zero;
    logic r_par;

    // Flags track the value being written into acc so they stay aligned with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_zero <= 1'b1;
            r_par  <= 1'b0;
        end else if (w_acc_en) begin
            r_zero <= (w_acc_d == '0);
            r_par  <= ^w_acc_d;
        end
    end

    assign bus.res_zero = r_zero;
    assign bus.res_par  = r_par;
`endif

    // in_ready is gated by reset_n so it reads 0 while reset is held.
    assign bus.in_ready  = w_ready & reset_n;
    assign bus.res_valid = w_res_valid;
    assign bus.res_data  = r_acc;
    assign bus.res_count = r_cnt;
    assign bus.ul_A      = r_acc;
    assign bus.ul_B      = r_b;
    assign bus.ul_S      = r_s;
endmodule

// File: tb/tb_ul4_acc_seq.sv
// ----------------------------------------------------------------------------
// tb_ul4_acc_seq
// Directed bench for ul4_acc_seq with a behavioural ul4 and a sequence-level
// reference model (expected result per completed sequence in a queue).
// ul4 select table used here: 0=AND, 1=OR, 2=XOR, 3=NOT A.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ul4_acc_seq;
    localparam int W  = 4;
    localparam int CW = 4;
    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ul4_acc_seq_if #(.W(W), .CW(CW)) bus ();

    ul4_acc_seq #(.W(W), .CW(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [W-1:0] ul4_f(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [1:0] s);
        case (s)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    assign bus.ul_Out = ul4_f(bus.ul_A, bus.ul_B, bus.ul_S);

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0]  data;
        logic [CW-1:0] cnt;
    } res_t;
    res_t exp_q[$];

    logic [W-1:0]  m_acc = '0;
    int            m_cnt = 0;
    bit            m_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sequence-level model: a beat either (re)loads or applies one operation.
    task automatic model_beat(input bit first, input bit last,
                              input logic [W-1:0] b, input logic [1:0] s);
        res_t r;
        if (!m_active || first) begin
            m_acc = b;
            m_cnt = 0;
        end else begin
            m_acc = ul4_f(m_acc, b, s);
            m_cnt = (m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
        end
        if (last) begin
            r.data = m_acc;
            r.cnt  = CW'(m_cnt);
            exp_q.push_back(r);
            m_active = 1'b0;
        end else begin
            m_active = 1'b1;
        end
    endtask

    // Called and returns at posedge+1.
    task automatic send(input bit first, input bit last,
                        input logic [W-1:0] b, input logic [1:0] s);
        int n;
        bus.in_valid = 1'b1;
        bus.in_first = first;
        bus.in_last  = last;
        bus.in_B     = b;
        bus.in_S     = s;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        model_beat(first, last, b, s);
        #1;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic get_result(input int hold, input logic [W-1:0] exp_d,
                              input logic [CW-1:0] exp_c);
        int n;
        logic [W-1:0] d0;
        n = 0;
        while (!bus.res_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("res_valid_wait", 32'(bus.res_valid), 32'd1);
        check("res_data_lit", 32'(bus.res_data), 32'(exp_d));
        check("res_count_lit", 32'(bus.res_count), 32'(exp_c));
        d0 = bus.res_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(bus.res_valid), 32'd1);
            check("hold_data", 32'(bus.res_data), 32'(d0));
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        check("idle_res_valid", 32'(bus.res_valid), 32'd0);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    // Result consumption retires the model's oldest expectation.
    always @(posedge clk) begin
        if (reset_n && bus.res_valid && bus.res_ready && exp_q.size() > 0)
            void'(exp_q.pop_front());
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            check("ready_valid_excl", 32'(bus.in_ready & bus.res_valid), 32'd0);
            check("ul_A_is_acc", 32'(bus.ul_A), 32'(bus.res_data));
            if (bus.res_valid) begin
                if (exp_q.size() == 0) begin
                    check("res_unexpected", 32'd1, 32'd0);
                end else begin
                    check("res_data", 32'(bus.res_data), 32'(exp_q[0].data));
                    check("res_count", 32'(bus.res_count), 32'(exp_q[0].cnt));
`ifdef UL4_ACC_FLAGS_EN
                    check("res_zero", 32'(bus.res_zero), 32'(exp_q[0].data == '0));
                    check("res_par", 32'(bus.res_par), 32'(^exp_q[0].data));
`endif
                end
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_B      = '0;
        bus.in_S      = '0;
        bus.res_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        check("rst_res_count", 32'(bus.res_count), 32'd0);
        check("rst_ul_B", 32'(bus.ul_B), 32'd0);
        check("rst_ul_S", 32'(bus.ul_S), 32'd0);
`ifdef UL4_ACC_FLAGS_EN
        check("rst_zero", 32'(bus.res_zero), 32'd1);
        check("rst_par", 32'(bus.res_par), 32'd0);
`endif
        reset_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // 1. reset in the middle of EXEC
        send(1'b1, 1'b0, 4'b0101, OP_AND);
        send(1'b0, 1'b0, 4'b0011, OP_OR);
        check("t1_exec_in_ready", 32'(bus.in_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        m_active = 1'b0;
        check("t1_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("t1_rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("t1_rst_acc", 32'(bus.res_data), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("t1_rel_in_ready", 32'(bus.in_ready), 32'd1);
        check("t1_rel_res_valid", 32'(bus.res_valid), 32'd0);

        // 2. single AND
        send(1'b1, 1'b0, 4'b1100, OP_AND);
        send(1'b0, 1'b1, 4'b1010, OP_AND);
        check("t2_exec_res_valid", 32'(bus.res_valid), 32'd0);
        check("t2_exec_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        check("t2_done_res_valid", 32'(bus.res_valid), 32'd1);
        get_result(0, 4'b1000, 4'd1);

        // 3. OR then XOR
        send(1'b1, 1'b0, 4'b0011, OP_AND);
        send(1'b0, 1'b0, 4'b0100, OP_OR);
        check("t3_exec1_in_ready", 32'(bus.in_ready), 32'd0);
        check("t3_exec1_ul_B", 32'(bus.ul_B), 32'b0100);
        check("t3_exec1_ul_S", 32'(bus.ul_S), 32'(OP_OR));
        send(1'b0, 1'b1, 4'b1111, OP_XOR);
        check("t3_exec2_in_ready", 32'(bus.in_ready), 32'd0);
        get_result(0, 4'b1000, 4'd2);

        // 4. first+last in one beat
        send(1'b1, 1'b1, 4'b0110, OP_XOR);
        check("t4_done_next", 32'(bus.res_valid), 32'd1);
        get_result(0, 4'b0110, 4'd0);

        // 5. restart mid-sequence, 6. held result
        send(1'b1, 1'b0, 4'b0001, OP_AND);
        send(1'b0, 1'b0, 4'b0010, OP_OR);
        @(posedge clk); #1;
        check("t5_pre_acc", 32'(bus.res_data), 32'b0011);
        send(1'b1, 1'b0, 4'b1001, OP_AND);
        check("t5_restart_acc", 32'(bus.res_data), 32'b1001);
        check("t5_restart_cnt", 32'(bus.res_count), 32'd0);
        send(1'b0, 1'b1, 4'b1111, OP_XOR);
        get_result(5, 4'b0110, 4'd1);

        // Count saturation over 17 ops, result zero
        send(1'b1, 1'b0, 4'b0000, OP_AND);
        for (int i = 0; i < 17; i++)
            send(1'b0, (i == 16), 4'b0000, OP_OR);
        get_result(0, 4'b0000, 4'd15);
`ifdef UL4_ACC_FLAGS_EN
        check("t6_zero_flag_post", 32'(bus.res_zero), 32'd1);
        check("t6_par_flag_post", 32'(bus.res_par), 32'd0);
`endif

        repeat (2) @(posedge clk); #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
